// File: rtl/masked_barrett_sched.sv
// rtl/masked_barrett_sched.sv - round-robin, credit-gated issue scheduler for the masked Barrett datapath
// Optional macro MASKED_BARRETT_SCHED_RND_GATE_EN adds rnd_valid gating of every issue.
module masked_barrett_sched #(
    parameter int LATENCY    = 20,
    parameter int FIFO_DEPTH = 24,
    parameter int IN_W       = 14,
    parameter int OUT_W      = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        zeroize,
    input  logic [1:0]                  req_valid,
    output logic [1:0]                  req_ready,
    input  logic [1:0][1:0][IN_W-1:0]   req_data,
    output logic                        dp_in_valid,
    output logic [1:0][IN_W-1:0]        dp_c_rolled,
    input  logic [1:0][OUT_W-1:0]       dp_arith_Q,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [1:0][OUT_W-1:0]       rsp_data,
    output logic                        rsp_id,
`ifdef MASKED_BARRETT_SCHED_RND_GATE_EN
    input  logic                        rnd_valid,
`endif
    output logic                        busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    logic [LATENCY-1:0] tag_valid;
    logic [LATENCY-1:0] tag_id;
    logic               rr_ptr;
    logic [CNT_W-1:0]   inflight_cnt;
    logic [CNT_W-1:0]   fifo_cnt;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    // Each share lives in its own register array; the two are never combined.
    logic [OUT_W-1:0]   fifo_s0 [FIFO_DEPTH];
    logic [OUT_W-1:0]   fifo_s1 [FIFO_DEPTH];
    logic               fifo_id [FIFO_DEPTH];

    logic               rnd_ok;
    logic               credit;
    logic               issue_ok;
    logic               grant_any;
    logic               grant_id;
    logic               capture;
    logic               pop;

`ifdef MASKED_BARRETT_SCHED_RND_GATE_EN
    assign rnd_ok = rnd_valid;
`else
    assign rnd_ok = 1'b1;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A slot is reserved for every token from issue until it leaves the FIFO.
    assign credit   = (SUM_W'(inflight_cnt) + SUM_W'(fifo_cnt)) < SUM_W'(FIFO_DEPTH);
    assign issue_ok = rst_n && credit && !zeroize && rnd_ok;

    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (issue_ok) begin
            case (req_valid)
                2'b01: begin
                    grant_any = 1'b1;
                    grant_id  = 1'b0;
                end
                2'b10: begin
                    grant_any = 1'b1;
                    grant_id  = 1'b1;
                end
                2'b11: begin
                    grant_any = 1'b1;
                    grant_id  = rr_ptr;
                end
                default: begin
                    grant_any = 1'b0;
                    grant_id  = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        req_ready   = 2'b00;
        dp_in_valid = grant_any;
        dp_c_rolled = '0;
        if (grant_any) begin
            req_ready[grant_id] = 1'b1;
            dp_c_rolled         = req_data[grant_id];
        end
    end

    assign capture   = tag_valid[LATENCY-1];
    assign rsp_valid = (fifo_cnt != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign busy      = (inflight_cnt != '0) || (fifo_cnt != '0);

    assign rsp_data[0] = fifo_s0[rd_ptr];
    assign rsp_data[1] = fifo_s1[rd_ptr];
    assign rsp_id      = fifo_id[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid <= '0;
            tag_id    <= '0;
            rr_ptr    <= 1'b0;
        end else if (zeroize) begin
            tag_valid <= '0;
            tag_id    <= '0;
            rr_ptr    <= 1'b0;
        end else begin
            tag_valid <= {tag_valid[LATENCY-2:0], grant_any};
            tag_id    <= {tag_id[LATENCY-2:0], grant_id};
            if (grant_any) begin
                rr_ptr <= ~grant_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_cnt <= '0;
            fifo_cnt     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else if (zeroize) begin
            inflight_cnt <= '0;
            fifo_cnt     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else begin
            case ({grant_any, capture})
                2'b10:   inflight_cnt <= inflight_cnt + CNT_W'(1);
                2'b01:   inflight_cnt <= inflight_cnt - CNT_W'(1);
                default: inflight_cnt <= inflight_cnt;
            endcase
            case ({capture, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (capture) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_s0[i] <= '0;
                fifo_s1[i] <= '0;
                fifo_id[i] <= 1'b0;
            end
        end else if (zeroize) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_s0[i] <= '0;
                fifo_s1[i] <= '0;
                fifo_id[i] <= 1'b0;
            end
        end else if (capture) begin
            fifo_s0[wr_ptr] <= dp_arith_Q[0];
            fifo_s1[wr_ptr] <= dp_arith_Q[1];
            fifo_id[wr_ptr] <= tag_id[LATENCY-1];
        end
    end

    // Credit should make this unreachable; it guards a mismatched LATENCY or depth.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(capture && !zeroize && (fifo_cnt == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_masked_barrett_sched.sv
// tb/tb_masked_barrett_sched.sv - scoreboard bench for masked_barrett_sched
module tb_masked_barrett_sched;

    localparam int LAT   = 20;
    localparam int DEPTH = 24;
    localparam int IN_W  = 14;
    localparam int OUT_W = 12;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       zeroize = 1'b0;
    logic [1:0]                 req_valid = 2'b00;
    logic [1:0]                 req_ready;
    logic [1:0][1:0][IN_W-1:0]  req_data = '0;
    logic                       dp_in_valid;
    logic [1:0][IN_W-1:0]       dp_c_rolled;
    logic [1:0][OUT_W-1:0]      dp_arith_Q;
    logic                       rsp_valid;
    logic                       rsp_ready = 1'b0;
    logic [1:0][OUT_W-1:0]      rsp_data;
    logic                       rsp_id;
    logic                       busy;
`ifdef MASKED_BARRETT_SCHED_RND_GATE_EN
    logic                       rnd_valid = 1'b1;
`endif

    masked_barrett_sched #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .zeroize    (zeroize),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .dp_in_valid(dp_in_valid),
        .dp_c_rolled(dp_c_rolled),
        .dp_arith_Q (dp_arith_Q),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
`ifdef MASKED_BARRETT_SCHED_RND_GATE_EN
        .rnd_valid  (rnd_valid),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Directed input shares and their hand-reduced (mod 3329) results.
    logic [IN_W-1:0]  tab_in  [8] = '{14'h0A5F, 14'h0123, 14'h0D01, 14'h1000,
                                      14'h3FFF, 14'h0D00, 14'h1A02, 14'h2000};
    logic [OUT_W-1:0] tab_out [8] = '{12'hA5F, 12'h123, 12'h000, 12'h2FF,
                                      12'hBFB, 12'hD00, 12'h000, 12'h5FE};

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int idx [2] = '{0, 4};
    int issue_cnt = 0;
    int issue_cyc = 0;
    logic [31:0] exp_q [$];
    int          grant_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural stand-in for the reduction datapath: fixed LAT-cycle pipe.
    function automatic logic [OUT_W-1:0] red(input logic [IN_W-1:0] x);
        int v;
        v = int'(x) % 3329;
        return OUT_W'(v);
    endfunction

    logic [1:0][OUT_W-1:0] dp_pipe [LAT] = '{default: '0};
    always @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) dp_pipe[k] <= dp_pipe[k-1];
        dp_pipe[0][0] <= dp_in_valid ? red(dp_c_rolled[0]) : '0;
        dp_pipe[0][1] <= dp_in_valid ? red(dp_c_rolled[1]) : '0;
    end
    assign dp_arith_Q = dp_pipe[LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            req_data[i][0] = tab_in[idx[i] % 8];
            req_data[i][1] = tab_in[(idx[i] + 1) % 8];
        end
    end

    // Monitor: records issues into the scoreboard and checks every response.
    always @(negedge clk) begin
        logic xfer;
        logic [31:0] e;
        if (!rst_n) begin
            exp_q.delete();
        end else if (zeroize) begin
            check("zeroize_req_ready", 64'(req_ready), 64'(0));
            check("zeroize_dp_in_valid", 64'(dp_in_valid), 64'(0));
            exp_q.delete();
        end else begin
            xfer = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    xfer = 1'b1;
                    check("issue_valid", 64'(dp_in_valid), 64'(1));
                    check("issue_data", 64'(dp_c_rolled), 64'(req_data[i]));
                    exp_q.push_back({7'd0, i[0], tab_out[(idx[i] + 1) % 8], tab_out[idx[i] % 8]});
                    grant_q.push_back(i);
                    issue_cnt++;
                    issue_cyc = cyc;
                    idx[i]++;
                end
            end
            if (!xfer) check("idle_dp", {31'd0, dp_in_valid, 4'd0, dp_c_rolled}, 64'(0));
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 64'({rsp_id, rsp_data}), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("rsp", 64'({7'd0, rsp_id, rsp_data}), 64'(e));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int bound);
        bit done;
        done = 1'b0;
        for (int n = 0; n < bound && !done; n++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        check("drain_timeout", 64'(done), 64'(1));
        check("drain_queue_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int base;
        logic acc;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_dp", {31'd0, dp_in_valid, 4'd0, dp_c_rolled}, 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_rsp_data", 64'({rsp_id, rsp_data}), 64'(0));
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        step();

        // Single issue latency
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (rsp_valid) found = 1'b1;
        end
        check("single_rsp_seen", 64'(found), 64'(1));
        check("single_latency", 64'(cyc - issue_cyc), 64'(21));
        check("single_rsp_data", 64'({rsp_id, rsp_data}), {39'd0, 1'b0, 12'h123, 12'hA5F});
        drain(50);

        // Zeroize resets the RR pointer, then both requesters contend
        step();
        zeroize = 1'b1;
        step();
        zeroize = 1'b0;
        grant_q.delete();
        req_valid = 2'b11;
        repeat (8) step();
        req_valid = 2'b00;
        check("rr_grant_count", 64'(grant_q.size()), 64'(8));
        for (int k = 0; k < grant_q.size(); k++) check("rr_grant_order", 64'(grant_q[k]), 64'(k % 2));
        drain(60);

        // Credit limit with a stalled consumer
        rsp_ready = 1'b0;
        base = issue_cnt;
        req_valid = 2'b01;
        repeat (60) step();
        check("credit_issue_count", 64'(issue_cnt - base), 64'(DEPTH));
        check("credit_blocked", 64'(req_ready), 64'(0));
        rsp_ready = 1'b1;
        @(negedge clk);
        check("credit_pop_cycle_ready", 64'(req_ready), 64'(0));
        step();
        rsp_ready = 1'b0;
        @(negedge clk);
        check("credit_one_more_ready", 64'(req_ready), 64'(2'b01));
        repeat (10) step();
        check("credit_issue_count_after_pop", 64'(issue_cnt - base), 64'(DEPTH + 1));
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        drain(200);

        // Steady stream: simultaneous push and pop
        step();
        req_valid = 2'b01;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (c >= 22) begin
                check("stream_rsp_valid", 64'(rsp_valid), 64'(1));
                check("stream_fifo_cnt", 64'(dut.fifo_cnt), 64'(1));
            end
            step();
        end
        req_valid = 2'b00;
        drain(60);

        // Zeroize with 10 in flight and 5 buffered
        rsp_ready = 1'b0;
        step();
        req_valid = 2'b01;
        repeat (15) step();
        req_valid = 2'b00;
        repeat (10) step();
        check("zpre_fifo_cnt", 64'(dut.fifo_cnt), 64'(5));
        check("zpre_inflight_cnt", 64'(dut.inflight_cnt), 64'(10));
        zeroize = 1'b1;
        req_valid = 2'b11;
        step();
        zeroize = 1'b0;
        req_valid = 2'b00;
        check("zpost_rsp_valid", 64'(rsp_valid), 64'(0));
        check("zpost_busy", 64'(busy), 64'(0));
        check("zpost_rsp_data", 64'({rsp_id, rsp_data}), 64'(0));
        acc = 1'b0;
        for (int k = 0; k < DEPTH; k++) acc = acc | (|dut.fifo_s0[k]) | (|dut.fifo_s1[k]) | dut.fifo_id[k];
        check("zpost_storage_zero", 64'(acc), 64'(0));
        rsp_ready = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            acc = acc | rsp_valid | busy;
        end
        check("zpost_no_stale", 64'(acc), 64'(0));

        // Async reset mid-stream
        step();
        req_valid = 2'b11;
        repeat (25) step();
        check("areset_pre_active", 64'({rsp_valid, busy}), 64'(2'b11));
        #3;
        rst_n = 1'b0;
        #1;
        check("areset_req_ready", 64'(req_ready), 64'(0));
        check("areset_dp", {31'd0, dp_in_valid, 4'd0, dp_c_rolled}, 64'(0));
        check("areset_rsp", 64'({rsp_valid, busy, rsp_id, rsp_data}), 64'(0));
        @(posedge clk);
        #1;
        grant_q.delete();
        rst_n = 1'b1;
        repeat (4) step();
        req_valid = 2'b00;
        check("areset_grants", 64'(grant_q.size()), 64'(4));
        if (grant_q.size() >= 2) begin
            check("areset_first_tie", 64'(grant_q[0]), 64'(0));
            check("areset_second", 64'(grant_q[1]), 64'(1));
        end
        drain(60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/masked_barrett_sched.md
Name: masked_barrett_sched

Overview:
- Fixed-latency issue scheduler for the masked Barrett conditional-subtract datapath.
- Shares one non-stallable datapath between two requesters (NTT lanes 0/1) using a round-robin arbiter.
- Tracks in-flight tokens with a tag shift register and buffers results in a share-preserving response FIFO.
- Uses credit-based issue so the datapath never produces a result with nowhere to go.

Parameters:
- LATENCY, 20, cycles from dp_in_valid to valid dp_arith_Q; must match the datapath.
- FIFO_DEPTH, 24, response FIFO entries; must be >= LATENCY+1.
- IN_W, 14, per-share input width (rolled coefficient).
- OUT_W, 12, per-share output width (MLKEM_Q_WIDTH).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- zeroize  in  1  synchronous wipe of all state and stored shares
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester grant; a transfer occurs when valid&ready
- req_data  in  2x2xIN_W  per-requester two-share masked input
- dp_in_valid  out  1  issue strobe to datapath
- dp_c_rolled  out  2xIN_W  shares driven to datapath; all zeros when not issuing
- dp_arith_Q  in  2xOUT_W  datapath result shares
- rsp_valid  out  1  FIFO head valid
- rsp_ready  in  1  consumer accept
- rsp_data  out  2xOUT_W  result shares at FIFO head
- rsp_id  out  1  requester index of the head entry
- busy  out  1  high when in-flight count or FIFO count is non-zero

Behaviour:
- Reset (rst_n=0, asynchronous) sets every output and register to 0:
  - req_ready, dp_in_valid, rsp_valid, busy all 0; data outputs 0.
  - RR pointer = 0, so requester 0 wins the first tie.
  - inflight_cnt = 0, fifo_cnt = 0, read and write pointers = 0.
- Credit rule: issue is allowed only when inflight_cnt + fifo_cnt < FIFO_DEPTH. A pop in the same cycle is not credited until the next cycle.
- Arbitration (combinational):
  - If credit is available and any req_valid is set: one grant per cycle.
  - One valid requester is granted directly.
  - When both are valid, the grant goes to the requester not granted last; the pointer updates on each grant.
  - req_ready is 0 for all requesters when there is no credit.
  - Requesters hold req_data stable while valid&&!ready.
- Issue: on a grant, dp_in_valid=1 and dp_c_rolled=req_data[grant] in the same cycle. A tag {valid, id} enters stage 0 of a LATENCY-deep shift register.
- Capture:
  - When stage LATENCY-1 is valid, dp_arith_Q is written to FIFO[wr_ptr] with its id at that clock edge.
  - rsp_valid rises one cycle later.
  - Issue at cycle t yields rsp_valid at cycle t+LATENCY+1.
- inflight_cnt increments on issue and decrements on capture. Both in the same cycle leaves it unchanged.
- FIFO:
  - Pop occurs when rsp_valid && rsp_ready; push and pop may happen in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - Credit makes overflow impossible. An assertion flags a push while full.
  - Popping empty is ignored.
  - Responses are delivered in issue order.
- Shares are never recombined or XORed together inside the block. Entries are stored and moved as separate share registers.
- Zeroize (synchronous, highest priority after reset):
  - Clears tags, counters, pointers, RR pointer and all FIFO share storage to 0.
  - Results already in flight are discarded.
  - req_ready=0 during the zeroize cycle.
- busy = (inflight_cnt != 0) || (fifo_cnt != 0).

Optional Feature:
- Macro: MASKED_BARRETT_SCHED_RND_GATE_EN.
- When defined:
  - Adds input rnd_valid (1 bit), driven by the PRNG.
  - An issue additionally requires rnd_valid=1 in the issue cycle; otherwise all req_ready=0 and the RR pointer holds.
  - Datapath randomness is then guaranteed fresh for every issued coefficient.
- When undefined: no port is added, and randomness is treated as always valid.

Test Plan:
- Single issue: req_valid=01, data {share1=0x0123, share0=0x0A5F}, issue at cycle 0 -> dp_in_valid at cycle 0, rsp_valid at cycle 21, rsp_id=0, rsp_data equals the model-reduced shares.
- Round-robin: both requesters valid continuously for 8 cycles -> grants alternate 0,1,0,1,0,1,0,1; rsp_id sequence matches in order.
- Back-pressure/credit: rsp_ready=0, streaming requests -> exactly 24 issues accepted, then req_ready=0 forever. Raising rsp_ready for 1 cycle -> exactly one further issue, in the following cycle.
- Simultaneous push/pop: steady stream with rsp_ready=1 -> fifo_cnt stays at 1 and throughput is 1 result per cycle with no overflow assertion.
- Zeroize mid-operation: 10 in flight plus 5 in FIFO, zeroize for 1 cycle -> next cycle rsp_valid=0, busy=0, all stored shares read 0, and no stale result emerges within 25 cycles.
- Async reset mid-stream: rst_n low between clock edges -> outputs go to 0 immediately; after release, requester 0 wins the first tie.
